demux_route_sequencer: RTL and testbench
========================================

Name: demux_route_sequencer

Overview:
- Buffers (data, destination) routing requests and drives them, one at a time, onto the 1-to-8 demux `in`/`sel` inputs.
- Holds each route for a fixed number of cycles and preserves request order.
- Provides a valid/ready request interface, a FIFO of depth DEPTH, and a hold counter.
- Sits directly upstream of the 1-to-8 demultiplexer: `dmx_in` connects to demux `in`, `dmx_sel` to demux `sel`.

Parameters:
- DEPTH, 4: FIFO entries. Power of 2, ≥2.
- HOLD_CYCLES, 4: cycles each route is presented on the dmx outputs. ≥1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_data  in  1  bit to route.
- req_sel  in  3  destination channel 0..7.
- flush  in  1  synchronous clear of queue and active route.
- dmx_in  out  1  to demux `in`.
- dmx_sel  out  3  to demux `sel`.
- busy  out  1  route active or queue non-empty.
- count  out  $clog2(DEPTH)+1  queued entries; excludes the active route.

Behaviour:
- Interface (already decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (rst_n=0, immediate, no clock needed):
  - dmx_in=0, dmx_sel=000, count=0, busy=0, state=IDLE, FIFO pointers=0.
  - req_ready=0 while rst_n=0.
- req_ready = rst_n && !flush && (count < DEPTH). Combinational from registered count only; no same-cycle bypass from a pop.
- Push:
  - Occurs on an edge where req_valid && req_ready.
  - Writes {req_data, req_sel} at the tail; count+1.
  - req_data/req_sel are ignored when no push occurs.
- Pop occurs only as defined by the FSM; count−1. Push and pop on the same edge leave count unchanged.
- FSM states: IDLE, HOLD.
  - IDLE: if count≠0, pop head; register dmx_in=data, dmx_sel=sel; hold counter=HOLD_CYCLES−1; go to HOLD. Otherwise stay; dmx_in=0.
  - HOLD, hold counter≠0: decrement; outputs stable.
  - HOLD, hold counter=0, count≠0: pop next entry and load it exactly as from IDLE; stay in HOLD. No gap cycle between consecutive routes.
  - HOLD, hold counter=0, count=0: go to IDLE; dmx_in=0; dmx_sel retains its last value.
- Timing and latency:
  - Each route is presented for exactly HOLD_CYCLES cycles.
  - Latency: a request pushed at edge N into an empty, idle block appears on dmx outputs after edge N+1.
  - The pop decision uses count before the edge, so an entry pushed at edge N is never popped at edge N.
- busy = (state==HOLD) || (count≠0).
- Flush (synchronous, highest priority after reset), at the next edge:
  - count=0, pointers=0, state=IDLE, dmx_in=0, dmx_sel unchanged.
  - A request presented in the flush cycle is not accepted (req_ready=0).
- Full: at count=DEPTH, req_ready=0. A pop at edge M makes count=DEPTH−1 and req_ready=1 during the following cycle.
- Reset mid-operation: the queued entries and the active route are discarded; outputs return to reset values immediately.
- Pointer wrap-around is modulo DEPTH. count never exceeds DEPTH and never underflows.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 asserted asynchronously mid-cycle.
   - Response: dmx_in=0, dmx_sel=000, count=0, busy=0, req_ready=0 immediately.
   - After release: req_ready=1, no dmx activity.
2. Single route (DEPTH=4, HOLD_CYCLES=4):
   - Stimulus: push data=1, sel=101 at edge 0.
   - Response: dmx_sel=101, dmx_in=1 from after edge 1 for exactly 4 cycles; then dmx_in=0, dmx_sel stays 101, busy=0.
3. Stream with back-pressure:
   - Stimulus: req_valid=1 every cycle with sel=000..111, data=1.
   - Response: req_ready drops once count=4 and reasserts one cycle after each pop.
   - Outputs walk 000→111 in order, each held 4 cycles, 32 consecutive cycles of dmx_in=1, no gaps, no loss.
4. Full boundary:
   - Stimulus: queue full (count=4) with req_valid held high.
   - Response: no push while req_ready=0; count goes 4→3 on the pop edge, then returns to 4 on the next edge with one push.
5. Flush mid-hold:
   - Stimulus: flush=1 in cycle 2 of a hold with 3 entries queued and req_valid=1.
   - Response: next edge gives dmx_in=0, count=0, busy=0, IDLE. The concurrent request is dropped.
   - A later push routes normally.
6. Reset mid-operation:
   - Stimulus: rst_n pulsed low during HOLD with 2 queued entries.
   - Response: outputs zero immediately; after release, no stale route appears and count=0.

Source files
------------

// File: rtl/demux_route_sequencer.sv
// demux_route_sequencer
//   Queues (data, destination) routing requests and presents them one at a
//   time on the in/sel inputs of a downstream 1-to-8 demultiplexer. Each
//   route is held for HOLD_CYCLES cycles. Back-to-back routes follow each
//   other with no idle cycle. Request order is preserved.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted on this edge if req_valid is also high
//   req_data   bit to route
//   req_sel    destination channel 0..7
//   flush      synchronous clear of the queue and of the active route
//   dmx_in     to demux `in`
//   dmx_sel    to demux `sel`
//   busy       a route is active or the queue is non-empty
//   count      number of queued entries (the active route is not counted)
module demux_route_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_data,
    input  logic [2:0]               req_sel,
    input  logic                     flush,
    output logic                     dmx_in,
    output logic [2:0]               dmx_sel,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef struct packed {
        logic       data;
        logic [2:0] sel;
    } route_t;

    typedef enum logic {IDLE, HOLD} state_t;

    route_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt, hold_cnt_nxt;
    logic            dmx_in_nxt;
    logic [2:0]      dmx_sel_nxt;
    logic            push, pop;
    route_t          head;

    // Ready comes from registered count only, so a pop on this edge does
    // not open a slot until the following cycle.
    assign req_ready = rst_n && !flush && (count < CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign busy      = (state == HOLD) || (count != '0);
    assign head      = mem[rd_ptr];

    // ---------------------------------------------------------------
    // Route FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            dmx_in   <= 1'b0;
            dmx_sel  <= 3'b000;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            dmx_in   <= dmx_in_nxt;
            dmx_sel  <= dmx_sel_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Route FSM: next state / pop decision
    // The pop decision looks at count before the edge, so an entry pushed
    // on this edge can never be popped on the same edge.
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        dmx_in_nxt   = dmx_in;
        dmx_sel_nxt  = dmx_sel;
        pop          = 1'b0;
        if (flush) begin
            // dmx_sel is deliberately left at its last value
            state_nxt  = IDLE;
            dmx_in_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        pop          = 1'b1;
                        dmx_in_nxt   = head.data;
                        dmx_sel_nxt  = head.sel;
                        hold_cnt_nxt = HW'(HOLD_CYCLES - 1);
                        state_nxt    = HOLD;
                    end else begin
                        dmx_in_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt_nxt = hold_cnt - HW'(1);
                    end else if (count != '0) begin
                        // chain straight into the next route, no gap cycle
                        pop          = 1'b1;
                        dmx_in_nxt   = head.data;
                        dmx_sel_nxt  = head.sel;
                        hold_cnt_nxt = HW'(HOLD_CYCLES - 1);
                    end else begin
                        state_nxt  = IDLE;
                        dmx_in_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    dmx_in_nxt = 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FIFO pointers and occupancy. DEPTH is a power of two so pointers
    // wrap naturally.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: req_data, sel: req_sel};
    end

endmodule

// File: tb/tb_demux_route_sequencer.sv
module tb_demux_route_sequencer;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_data;
    logic [2:0] req_sel;
    logic       flush;
    logic       dmx_in;
    logic [2:0] dmx_sel;
    logic       busy;
    logic [2:0] count;

    demux_route_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_sel(req_sel), .flush(flush),
        .dmx_in(dmx_in), .dmx_sel(dmx_sel), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // scoreboard of accepted requests, {data, sel}, plus behavioural state
    logic [3:0] sb [$];
    logic       m_hold;
    int         m_hcnt;
    logic       m_in;
    logic [2:0] m_sel;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_ready();
        return (rst_n && !flush && sb.size() < DEPTH) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".dmx_in"},    int'(dmx_in),    int'(m_in));
        chk({tag, ".dmx_sel"},   int'(dmx_sel),   int'(m_sel));
        chk({tag, ".count"},     int'(count),     sb.size());
        chk({tag, ".busy"},      int'(busy),      (m_hold || sb.size() != 0) ? 1 : 0);
        chk({tag, ".req_ready"}, int'(req_ready), m_ready());
    endtask

    function automatic void m_reset();
        sb.delete();
        m_hold = 1'b0;
        m_hcnt = 0;
        m_in   = 1'b0;
        m_sel  = 3'b000;
    endfunction

    // Called at the negedge with inputs already driven: advance one edge,
    // update the model, then compare at the following negedge.
    task automatic tick(input string tag, output bit pushed);
        bit push, pop;
        push   = req_valid && (m_ready() != 0);
        pop    = !flush && sb.size() != 0 && (!m_hold || m_hcnt == 0);
        pushed = push;
        @(posedge clk);
        if (flush) begin
            sb.delete();
            m_hold = 1'b0;
            m_in   = 1'b0;
        end else begin
            if (pop) begin
                logic [3:0] e;
                e      = sb.pop_front();
                m_in   = e[3];
                m_sel  = e[2:0];
                m_hcnt = HOLD - 1;
                m_hold = 1'b1;
            end else if (m_hold && m_hcnt != 0) begin
                m_hcnt--;
            end else if (m_hold) begin
                m_hold = 1'b0;
                m_in   = 1'b0;
            end
            if (push) sb.push_back({req_data, req_sel});
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic d, input logic [2:0] s);
        req_valid = v;
        req_data  = d;
        req_sel   = s;
    endtask

    initial begin
        bit p;
        int hi_cnt, first_hi, last_hi, cyc, sent;
        bit saw_full;

        rst_n = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 3'b000);
        m_reset();
        #12;
        // 1. reset values while rst_n is low
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.release_ready", int'(req_ready), 1);
        @(negedge clk);
        tick("idle", p);
        chk("idle.no_activity", int'(dmx_in), 0);

        // 2. single route, data=1 sel=101
        drive(1'b1, 1'b1, 3'b101);
        tick("single.push", p);
        chk("single.pushed", int'(p), 1);
        chk("single.not_yet", int'(dmx_in), 0);
        drive(1'b0, 1'b0, 3'b000);
        hi_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick("single.run", p);
            if (i == 0) begin
                chk("single.latency_in",  int'(dmx_in),  1);
                chk("single.latency_sel", int'(dmx_sel), 5);
            end
            if (dmx_in) hi_cnt++;
        end
        chk("single.hold_len", hi_cnt, HOLD);
        chk("single.sel_kept", int'(dmx_sel), 5);
        chk("single.busy_end", int'(busy), 0);

        // 3. stream 000..111 with back-pressure
        sent = 0; hi_cnt = 0; first_hi = -1; last_hi = -1; saw_full = 0; cyc = 0;
        while ((sent < 8 || busy) && cyc < 200) begin
            drive(sent < 8, 1'b1, 3'(sent));
            if (sent < 8 && !req_ready) saw_full = 1;
            tick("stream", p);
            if (p) sent++;
            if (dmx_in) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = cyc;
                last_hi = cyc;
            end
            cyc++;
        end
        drive(1'b0, 1'b0, 3'b000);
        chk("stream.timeout",   (cyc < 200) ? 1 : 0, 1);
        chk("stream.all_sent",  sent, 8);
        chk("stream.hi_cycles", hi_cnt, 32);
        chk("stream.no_gaps",   last_hi - first_hi, 31);
        chk("stream.backpress", int'(saw_full), 1);
        chk("stream.last_sel",  int'(dmx_sel), 7);

        // 4. full boundary: fill to 4 queued, hold valid high
        cyc = 0;
        while (count != 3'd4 && cyc < 20) begin
            drive(1'b1, 1'b0, 3'(cyc));
            tick("full.fill", p);
            cyc++;
        end
        chk("full.reached", int'(count), 4);
        chk("full.ready_low", int'(req_ready), 0);
        cyc = 0;
        while (count == 3'd4 && cyc < 20) begin
            tick("full.wait", p);
            chk("full.no_push", int'(p), 0);
            cyc++;
        end
        chk("full.pop_to3",   int'(count), 3);
        chk("full.ready_up",  int'(req_ready), 1);
        tick("full.refill", p);
        chk("full.back_to4",  int'(count), 4);
        drive(1'b0, 1'b0, 3'b000);
        cyc = 0;
        while (busy && cyc < 100) begin tick("full.drain", p); cyc++; end
        chk("full.drained", int'(busy), 0);

        // 5. flush mid-hold with 3 queued and a concurrent request
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 3'(i + 1));
            tick("flush.fill", p);
        end
        chk("flush.queued", int'(count), 3);
        chk("flush.holding", int'(dmx_in), 1);
        flush = 1'b1;
        drive(1'b1, 1'b1, 3'b110);
        #1;
        chk("flush.ready_low", int'(req_ready), 0);
        @(negedge clk);
        tick("flush.edge", p);
        flush = 1'b0;
        chk("flush.dmx_in", int'(dmx_in), 0);
        chk("flush.count",  int'(count), 0);
        chk("flush.busy",   int'(busy), 0);
        chk("flush.sel_kept", int'(dmx_sel), 1);
        drive(1'b1, 1'b1, 3'b011);
        tick("flush.repush", p);
        drive(1'b0, 1'b0, 3'b000);
        tick("flush.route", p);
        chk("flush.route_sel", int'(dmx_sel), 3);
        chk("flush.route_in",  int'(dmx_in), 1);
        cyc = 0;
        while (busy && cyc < 100) begin tick("flush.drain", p); cyc++; end

        // 6. reset mid-operation with 2 queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 3'(i + 4));
            tick("rst.fill", p);
        end
        drive(1'b0, 1'b0, 3'b000);
        chk("rst.queued", int'(count), 2);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("rst.async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick("rst.after", p);
            chk("rst.no_stale", int'(dmx_in), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
